// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues reads to a synchronous
// instruction memory and buffers returned words with their PC for the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        DECODER_ENABLED,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFlush
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       inflight_pc_q, inflight_pc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [31:0]       instr_mem_q [QUEUE_DEPTH];
  logic [31:0]       pc_mem_q    [QUEUE_DEPTH];

  logic              not_empty;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CntW-1:0]   occupancy;

  // Occupancy counts the in-flight slot so a returning word always has room.
  always_comb begin
    not_empty = (count_q != '0);
    pop       = not_empty & ~STALL & ~REDIRECT;
    occupancy = count_q + CntW'(inflight_q);
    issue     = (state_q == StRun) & ((occupancy < DepthC) | pop);
    push      = inflight_q & (state_q == StRun) & ~REDIRECT;
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      StFlush: state_d = StRun;
      default: state_d = StBoot;
    endcase

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end

    if (push) begin
      tail_d = tail_q + PtrW'(1);
    end
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push) - CntW'(pop);

    // Redirect overrides everything, including a redirect already in flush.
    if (REDIRECT) begin
      state_d    = StFlush;
      fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[tail_q] <= IMEM_RDATA;
      pc_mem_q[tail_q]    <= inflight_pc_q;
    end
  end

  always_comb begin
    IMEM_REQ        = issue;
    IMEM_ADDR       = fetch_pc_q;
    DECODER_ENABLED = not_empty;
    INSTRUCTION     = not_empty ? instr_mem_q[head_q] : NOP_INSTR;
    PC              = not_empty ? pc_mem_q[head_q] : 32'h0000_0000;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an address-keyed memory model feeds the DUT and
// a scoreboard of expected PCs is checked against every instruction the decoder accepts.
module tb_fetch_unit;

  localparam logic [31:0] Key = 32'h5A5A_0000;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        DECODER_ENABLED;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] addr_log [$];
  logic [31:0] mon_e;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(2),
    .NOP_INSTR  (Nop)
  ) dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .IMEM_REQ       (IMEM_REQ),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_RDATA     (IMEM_RDATA),
    .STALL          (STALL),
    .REDIRECT       (REDIRECT),
    .REDIRECT_PC    (REDIRECT_PC),
    .DECODER_ENABLED(DECODER_ENABLED),
    .INSTRUCTION    (INSTRUCTION),
    .PC             (PC)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory: word is a keyed function of its address.
  always @(posedge CLK) begin
    IMEM_RDATA <= IMEM_REQ ? (IMEM_ADDR ^ Key) : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load_exp(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 200; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_de(output int n);
    n = 0;
    while (!DECODER_ENABLED && n < 20) begin
      @(negedge CLK);
      n++;
    end
  endtask

  // Scoreboard: every accepted instruction must be the next expected PC.
  always @(negedge CLK) begin
    if (RSTN && DECODER_ENABLED && !STALL && !REDIRECT) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed_pc=%h expected=none", PC);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", PC, mon_e);
        chk("sb_instr", INSTRUCTION, mon_e ^ Key);
      end
    end
    if (RSTN && IMEM_REQ) addr_log.push_back(IMEM_ADDR);
  end

  initial begin
    int n;
    logic [31:0] held_pc;
    logic [31:0] held_in;
    logic [31:0] a;

    load_exp(32'h0);
    repeat (3) @(negedge CLK);
    chk("rst_req", 32'(IMEM_REQ), 32'd0);
    chk("rst_de", 32'(DECODER_ENABLED), 32'd0);
    chk("rst_instr", INSTRUCTION, Nop);
    chk("rst_pc", PC, 32'h0);

    // Fill from reset
    @(posedge CLK); #1 RSTN = 1'b1;
    @(negedge CLK);
    chk("boot_req", 32'(IMEM_REQ), 32'd0);
    wait_de(n);
    chk("fill_latency", n, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stream_de", 32'(DECODER_ENABLED), 32'd1);
    end

    // Stall with a full queue
    @(posedge CLK); #1 STALL = 1'b1;
    repeat (2) @(negedge CLK);
    held_pc = PC;
    held_in = INSTRUCTION;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("stall_pc", PC, held_pc);
      chk("stall_instr", INSTRUCTION, held_in);
      chk("stall_req", 32'(IMEM_REQ), 32'd0);
      chk("stall_de", 32'(DECODER_ENABLED), 32'd1);
    end
    @(posedge CLK); #1 STALL = 1'b0;
    repeat (4) @(posedge CLK);

    // Redirect with a request in flight
    #1 REDIRECT = 1'b1;
    REDIRECT_PC = 32'h0000_0103;
    load_exp(32'h0000_0100);
    @(posedge CLK); #1 REDIRECT = 1'b0;
    addr_log.delete();
    @(negedge CLK);
    chk("flush_de", 32'(DECODER_ENABLED), 32'd0);
    chk("flush_req", 32'(IMEM_REQ), 32'd0);
    wait_de(n);
    chk("redirect_latency", n, 3);
    a = (addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF;
    chk("redirect_addr", a, 32'h0000_0100);
    repeat (3) @(posedge CLK);

    // Redirect and stall together with a full queue
    #1 STALL = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rs_full_de", 32'(DECODER_ENABLED), 32'd1);
    @(posedge CLK); #1 REDIRECT = 1'b1;
    REDIRECT_PC = 32'h0000_0200;
    load_exp(32'h0000_0200);
    @(posedge CLK); #1 REDIRECT = 1'b0;
    STALL = 1'b0;
    @(negedge CLK);
    chk("rs_de", 32'(DECODER_ENABLED), 32'd0);
    chk("rs_pc", PC, 32'h0);
    wait_de(n);
    chk("rs_latency", n, 3);
    repeat (3) @(posedge CLK);

    // Address wrap at the top of memory
    #1 REDIRECT = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFF8;
    load_exp(32'hFFFF_FFF8);
    @(posedge CLK); #1 REDIRECT = 1'b0;
    addr_log.delete();
    repeat (8) @(negedge CLK);
    chk("wrap_log_size", 32'(addr_log.size() >= 3), 32'd1);
    a = (addr_log.size() > 0) ? addr_log[0] : 32'h1;
    chk("wrap_addr0", a, 32'hFFFF_FFF8);
    a = (addr_log.size() > 1) ? addr_log[1] : 32'h1;
    chk("wrap_addr1", a, 32'hFFFF_FFFC);
    a = (addr_log.size() > 2) ? addr_log[2] : 32'h1;
    chk("wrap_addr2", a, 32'h0000_0000);

    // Asynchronous reset mid-stream
    @(posedge CLK); #3 RSTN = 1'b0;
    #1;
    chk("arst_de", 32'(DECODER_ENABLED), 32'd0);
    chk("arst_instr", INSTRUCTION, Nop);
    chk("arst_pc", PC, 32'h0);
    chk("arst_req", 32'(IMEM_REQ), 32'd0);
    load_exp(32'h0);
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    @(negedge CLK);
    chk("rerun_boot_de", 32'(DECODER_ENABLED), 32'd0);
    wait_de(n);
    chk("rerun_latency", n, 3);
    repeat (4) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
